// File: rtl/hsiao_ecc_pkg.sv
// Shared Hsiao SEC-DED definitions: size limits and the parity-check matrix
// used by both the encoder and the corrector.
package hsiao_ecc_pkg;

    localparam int unsigned MaxDataWidth   = 64;
    localparam int unsigned MaxParityWidth = 8;
    localparam int unsigned MaxTotalWidth  = MaxDataWidth + MaxParityWidth;

    typedef logic [MaxParityWidth-1:0][MaxDataWidth-1:0] hsiao_mat_t;

    function automatic int popcount(input int v);
        int n;
        n = 0;
        for (int b = 0; b < 32; b++) begin
            n += int'(v[b]);
        end
        return n;
    endfunction

    // Columns are odd-weight codes, lowest weight first and ascending value
    // within a weight, so the matrix is fully determined by (dw, pw).
    function automatic hsiao_mat_t hsiao_matrix(input int dw, input int pw);
        hsiao_mat_t m;
        int         col;
        m   = '0;
        col = 0;
        for (int w = 3; w <= pw; w += 2) begin
            for (int v = 1; v < (1 << pw); v++) begin
                if (col < dw && popcount(v) == w) begin
                    for (int i = 0; i < pw; i++) begin
                        m[i][col] = v[i];
                    end
                    col++;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/hsiao_ecc_enc.sv
// Combinational Hsiao encoder: appends ProtWidth parity bits above the data.
module hsiao_ecc_enc
    import hsiao_ecc_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ProtWidth = $clog2(DataWidth) + 2
) (
    input  logic [DataWidth-1:0]           data_i,
    output logic [DataWidth+ProtWidth-1:0] data_o
);

    localparam hsiao_mat_t H = hsiao_matrix(DataWidth, ProtWidth);

    logic [ProtWidth-1:0] parity;

    always_comb begin
        parity = '0;
        for (int i = 0; i < ProtWidth; i++) begin
            parity[i] = ^(data_i & H[i][DataWidth-1:0]);
        end
    end

    assign data_o = {parity, data_i};

endmodule

// File: rtl/hsiao_ecc_enc_stream.sv
// Streaming Hsiao encoder with a 2-entry skid buffer and handshake counter.
// Define HSIAO_ECC_ERR_INJECT_EN to XOR inject_i into each stored codeword.
module hsiao_ecc_enc_stream
    import hsiao_ecc_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned ProtWidth  = $clog2(DataWidth) + 2,
    parameter int unsigned TotalWidth = DataWidth + ProtWidth,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DataWidth-1:0]  data_i,
    input  logic [TotalWidth-1:0] inject_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [TotalWidth-1:0] data_o,
    output logic [CntWidth-1:0]   count_o,
    input  logic                  clear_i
);

    if (ProtWidth < $clog2(DataWidth) + 2 || ProtWidth > MaxParityWidth ||
        DataWidth > MaxDataWidth || TotalWidth > MaxTotalWidth) begin : g_param_err
        $error("hsiao_ecc_enc_stream: unsupported DataWidth/ProtWidth combination");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } buf_state_e;

    buf_state_e            state_q;
    logic                  valid_q;
    logic                  ready_q;
    logic [TotalWidth-1:0] head_q;
    logic [TotalWidth-1:0] skid_q;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [TotalWidth-1:0] enc_cw;
    logic [TotalWidth-1:0] codeword_d;
    logic                  push;
    logic                  pop;

    hsiao_ecc_enc #(
        .DataWidth (DataWidth),
        .ProtWidth (ProtWidth)
    ) u_enc (
        .data_i (data_i),
        .data_o (enc_cw)
    );

`ifdef HSIAO_ECC_ERR_INJECT_EN
    assign codeword_d = enc_cw ^ inject_i;
`else
    logic [TotalWidth-1:0] unused_inject;
    assign unused_inject = inject_i;
    assign codeword_d    = enc_cw;
`endif

    // Both handshakes use only registered flags, so ready_o never sees ready_i.
    assign push = valid_i & ready_q;
    assign pop  = valid_q & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        head_q  <= codeword_d;
                        state_q <= S_ONE;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_q <= codeword_d;
                    end else if (push) begin
                        skid_q  <= codeword_d;
                        state_q <= S_FULL;
                        ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q <= S_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        head_q  <= skid_q;
                        state_q <= S_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (pop) begin
            count_d = count_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign data_o  = head_q;
    assign count_o = count_q;

endmodule
